nios_processor_audio_frame_writer: RTL and testbench
====================================================

// Module: nios_processor_audio_frame_writer
// PURPOSE
// - Upstream feeder for port 2 (s2) of the dual-port on-chip RAM. Takes 16-bit stereo PCM samples from the audio
//   input path and writes them into a ping-pong pair of frame buffers in that RAM.
// - The Nios reads completed frames through port 1 and hands each frame back with frame_ack.
// - Port 2 has no waitrequest: each accepted sample becomes exactly one single-cycle word write.
// PARAMETERS
// - BASE_WORD    40000  word address of frame 0; frame 1 starts at BASE_WORD+FRAME_WORDS
// - FRAME_WORDS  1024   samples (words) per frame; must be >= 2; BASE_WORD+2*FRAME_WORDS <= 50000
// - ADDR_W       16     RAM word-address width
// - CNT_W        16     overflow counter width
// PORTS
// - clk             in   1       system clock (also drives RAM clk2)
// - reset           in   1       synchronous, active-high reset
// - enable          in   1       level; 1 = capture running
// - snk_valid       in   1       sample strobe from the audio input path
// - snk_left        in   16      left sample, two's complement
// - snk_right       in   16      right sample, two's complement
// - snk_ready       out  1       1 in FILL/WAIT_FREE; 0 in IDLE
// - mem_address     out  ADDR_W  to address2
// - mem_chipselect  out  1       to chipselect2
// - mem_write       out  1       to write2
// - mem_byteenable  out  4       to byteenable2; 4'hF on every write
// - mem_writedata   out  32      to writedata2 = {left,right}
// - mem_clken       out  1       to clken2; constant 1
// - frame_ack       in   1       one-cycle pulse from CPU: frame ack_idx has been consumed
// - ack_idx         in   1       frame index being acked
// - frame_done      out  1       one-cycle pulse: a frame has just been completed
// - frame_idx       out  1       index of last completed frame; valid from the frame_done cycle, held until the next
// - irq             out  1       level = full[0] | full[1]
// - overflow_count  out  CNT_W   samples dropped; saturates at all-ones
// BEHAVIOUR
// - Reset values:
//   - all outputs 0 except mem_clken = 1;
//   - state IDLE; full[1:0] = 0; cur = 0; offset = 0.
// - Outputs are registered. A sample accepted at cycle N produces, at cycle N+1:
//   - mem_write = mem_chipselect = 1, byteenable 4'hF;
//   - address = BASE_WORD + cur*FRAME_WORDS + offset;
//   - data = {snk_left,snk_right}.
//   - mem_write/mem_chipselect are 0 in every other cycle.
// - Accept condition: snk_valid & snk_ready. The source cannot stall, so snk_ready is a status flag, not backpressure.
// - States:
//   - IDLE: snk_ready = 0. enable = 1 -> FILL if full[cur] = 0, else WAIT_FREE.
//   - FILL: each accepted sample is written and offset increments.
//     When the accepted sample has offset == FRAME_WORDS-1:
//     - full[cur] is set;
//     - frame_done pulses and frame_idx = cur, in the same cycle as that word's write;
//     - cur toggles and offset -> 0;
//     - next state = WAIT_FREE if full[new cur] = 1, else FILL.
//   - WAIT_FREE: accepted samples are dropped (no RAM write) and overflow_count increments (saturating).
//     -> FILL the cycle after full[cur] clears.
//   - enable = 0 in any state -> IDLE next cycle:
//     - offset -> 0, so the partial frame is discarded;
//     - cur and full[] are kept;
//     - a write already accepted is still issued.
//     - A sample offered in the same cycle as enable falls is not accepted.
// - frame_ack clears full[ack_idx].
//   - Ack of a frame that is not full: ignored.
//   - Ack and completion of the same index in the same cycle: the set wins (full stays 1).
// - Wrap-around: offset wraps only at frame end; frames alternate 0,1,0,1...
//   The address never leaves [BASE_WORD, BASE_WORD+2*FRAME_WORDS-1].
// - Reset mid-frame: the next cycle shows no write, frame_done 0, irq 0 and overflow_count 0.
// TESTING (sim with FRAME_WORDS=4, BASE_WORD=40000)
// - Reset held 3 cycles -> snk_ready, mem_write, irq, frame_done all 0; overflow_count=0; mem_clken=1.
// - enable=1; samples L/R = 0x1111/0x2222, 0x3333/0x4444, 0x5555/0x6666, 0x7777/0x8888
//   -> writes to 40000..40003 with 0x11112222..0x77778888, each one cycle after its sample;
//   -> frame_done with frame_idx=0 on the write to 40003; irq=1.
// - 4 further samples, no ack -> writes to 40004..40007; frame_done with frame_idx=1;
//   -> next 3 samples: no mem_write, overflow_count=3.
// - frame_ack with ack_idx=0 -> next sample is written to 40000 and overflow_count stays 3;
//   -> irq stays 1 until frame_ack with ack_idx=1.
// - Fresh run: 2 samples, then enable=0, then enable=1 with sample 0xAAAA/0xBBBB
//   -> that sample is written to 40000 (offset restarted).
// - frame_ack with ack_idx=1 in the same cycle frame 1 completes -> full[1] stays 1 and irq stays 1.

Source files
------------

// File: rtl/nios_processor_audio_frame_writer_if.sv
// Purpose: bundles the sample sink, RAM port-2 write bus and CPU frame
//          handshake of the audio frame writer into one interface.
// Signals:
//   enable, snk_valid, snk_left, snk_right, snk_ready  - capture control / sample sink
//   mem_address, mem_chipselect, mem_write,
//   mem_byteenable, mem_writedata, mem_clken           - RAM port-2 write bus
//   frame_ack, ack_idx, frame_done, frame_idx, irq     - CPU frame handshake
//   overflow_count                                     - dropped-sample counter
// Modports:
//   master - the side that feeds samples and acks (audio path / CPU / bench)
//   slave  - the frame writer itself
interface nios_processor_audio_frame_writer_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 16
);
  logic              enable;
  logic              snk_valid;
  logic [15:0]       snk_left;
  logic [15:0]       snk_right;
  logic              snk_ready;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [3:0]        mem_byteenable;
  logic [31:0]       mem_writedata;
  logic              mem_clken;
  logic              frame_ack;
  logic              ack_idx;
  logic              frame_done;
  logic              frame_idx;
  logic              irq;
  logic [CNT_W-1:0]  overflow_count;

  modport master (
    output enable, snk_valid, snk_left, snk_right, frame_ack, ack_idx,
    input  snk_ready, mem_address, mem_chipselect, mem_write, mem_byteenable,
           mem_writedata, mem_clken, frame_done, frame_idx, irq, overflow_count
  );

  modport slave (
    input  enable, snk_valid, snk_left, snk_right, frame_ack, ack_idx,
    output snk_ready, mem_address, mem_chipselect, mem_write, mem_byteenable,
           mem_writedata, mem_clken, frame_done, frame_idx, irq, overflow_count
  );
endinterface

// File: rtl/nios_processor_audio_frame_writer.sv
// Purpose: writes 16-bit stereo PCM samples into a ping-pong pair of frame
//          buffers through port 2 of the dual-port on-chip RAM. The CPU reads
//          completed frames through port 1 and returns them with frame_ack.
// Ports:
//   clk   - system clock (also RAM clk2)
//   reset - synchronous, active-high
//   bus   - slave side of nios_processor_audio_frame_writer_if (sample sink,
//           RAM write bus, frame handshake, irq, overflow counter)
module nios_processor_audio_frame_writer #(
  parameter int unsigned BASE_WORD   = 40000,
  parameter int unsigned FRAME_WORDS = 1024,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned CNT_W       = 16
) (
  input logic                                clk,
  input logic                                reset,
  nios_processor_audio_frame_writer_if.slave bus
);

  localparam int unsigned       OFF_W       = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [OFF_W-1:0]  LAST_OFF    = OFF_W'(FRAME_WORDS - 1);
  localparam logic [ADDR_W-1:0] FRAME0_BASE = ADDR_W'(BASE_WORD);
  localparam logic [ADDR_W-1:0] FRAME1_BASE = ADDR_W'(BASE_WORD + FRAME_WORDS);

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StWaitFree
  } state_e;

  state_e             r_state;
  logic [1:0]         r_full;
  logic               r_cur;
  logic [OFF_W-1:0]   r_offset;
  logic               r_snk_ready;
  logic [ADDR_W-1:0]  r_mem_address;
  logic               r_mem_write;
  logic [3:0]         r_mem_byteenable;
  logic [31:0]        r_mem_writedata;
  logic               r_frame_done;
  logic               r_frame_idx;
  logic               r_irq;
  logic [CNT_W-1:0]   r_overflow_count;

  logic               w_accept;
  logic               w_last;
  logic               w_write;
  logic               w_complete;
  logic               w_drop;
  logic [1:0]         w_full_d;
  state_e             w_state_d;
  logic               w_cur_d;
  logic [OFF_W-1:0]   w_offset_d;
  logic [CNT_W-1:0]   w_overflow_d;
  logic [ADDR_W-1:0]  w_addr;

  // enable is part of the accept term so a sample offered as enable falls is ignored.
  assign w_accept   = bus.snk_valid & r_snk_ready & bus.enable;
  assign w_last     = (r_offset == LAST_OFF);
  assign w_write    = w_accept & (r_state == StFill);
  assign w_complete = w_write & w_last;
  assign w_drop     = w_accept & (r_state == StWaitFree);
  assign w_addr     = (r_cur ? FRAME1_BASE : FRAME0_BASE) + ADDR_W'(r_offset);

  // Ack clears first, completion sets afterwards: a same-cycle ack of the
  // frame being completed loses.
  always_comb begin
    w_full_d = r_full;
    if (bus.frame_ack) begin
      w_full_d[bus.ack_idx] = 1'b0;
    end
    if (w_complete) begin
      w_full_d[r_cur] = 1'b1;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_cur_d    = r_cur;
    w_offset_d = r_offset;
    if (!bus.enable) begin
      // Partial frame is discarded; cur and full[] survive.
      w_state_d  = StIdle;
      w_offset_d = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_state_d = r_full[r_cur] ? StWaitFree : StFill;
        end
        StFill: begin
          if (w_write) begin
            if (w_last) begin
              w_cur_d    = ~r_cur;
              w_offset_d = '0;
              w_state_d  = w_full_d[~r_cur] ? StWaitFree : StFill;
            end else begin
              w_offset_d = r_offset + OFF_W'(1);
            end
          end
        end
        StWaitFree: begin
          if (!r_full[r_cur]) begin
            w_state_d = StFill;
          end
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  always_comb begin
    w_overflow_d = r_overflow_count;
    if (w_drop && (r_overflow_count != {CNT_W{1'b1}})) begin
      w_overflow_d = r_overflow_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= StIdle;
      r_full           <= 2'b00;
      r_cur            <= 1'b0;
      r_offset         <= '0;
      r_snk_ready      <= 1'b0;
      r_mem_address    <= '0;
      r_mem_write      <= 1'b0;
      r_mem_byteenable <= 4'h0;
      r_mem_writedata  <= 32'h0;
      r_frame_done     <= 1'b0;
      r_frame_idx      <= 1'b0;
      r_irq            <= 1'b0;
      r_overflow_count <= '0;
    end else begin
      r_state          <= w_state_d;
      r_full           <= w_full_d;
      r_cur            <= w_cur_d;
      r_offset         <= w_offset_d;
      r_snk_ready      <= (w_state_d != StIdle);
      r_mem_write      <= w_write;
      r_mem_byteenable <= w_write ? 4'hF : 4'h0;
      if (w_write) begin
        r_mem_address   <= w_addr;
        r_mem_writedata <= {bus.snk_left, bus.snk_right};
      end
      // frame_done lines up with the write of the frame's last word.
      r_frame_done     <= w_complete;
      if (w_complete) begin
        r_frame_idx <= r_cur;
      end
      r_irq            <= |w_full_d;
      r_overflow_count <= w_overflow_d;
    end
  end

  assign bus.snk_ready      = r_snk_ready;
  assign bus.mem_address    = r_mem_address;
  assign bus.mem_chipselect = r_mem_write;
  assign bus.mem_write      = r_mem_write;
  assign bus.mem_byteenable = r_mem_byteenable;
  assign bus.mem_writedata  = r_mem_writedata;
  assign bus.mem_clken      = 1'b1;
  assign bus.frame_done     = r_frame_done;
  assign bus.frame_idx      = r_frame_idx;
  assign bus.irq            = r_irq;
  assign bus.overflow_count = r_overflow_count;

endmodule

// File: tb/tb_nios_processor_audio_frame_writer.sv
// Self-checking bench for nios_processor_audio_frame_writer with four-word
// frames and a narrow overflow counter so saturation is reachable.
module tb_nios_processor_audio_frame_writer;

  localparam int unsigned BASE = 40000;
  localparam int unsigned FW   = 4;
  localparam int unsigned AW   = 16;
  localparam int unsigned CW   = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  nios_processor_audio_frame_writer_if #(.ADDR_W(AW), .CNT_W(CW)) u_if ();

  nios_processor_audio_frame_writer #(
    .BASE_WORD  (BASE),
    .FRAME_WORDS(FW),
    .ADDR_W     (AW),
    .CNT_W      (CW)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (u_if.slave)
  );

  int total = 0;
  int bad   = 0;

  // {write, chipselect, byteenable, address, data, frame_done}
  logic [54:0] w_obs;
  assign w_obs = {u_if.mem_write, u_if.mem_chipselect, u_if.mem_byteenable,
                  u_if.mem_address, u_if.mem_writedata, u_if.frame_done};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [15:0] l, input logic [15:0] r);
    u_if.snk_valid = 1'b1;
    u_if.snk_left  = l;
    u_if.snk_right = r;
    cyc();
    u_if.snk_valid = 1'b0;
  endtask

  task automatic ack(input logic idx);
    u_if.frame_ack = 1'b1;
    u_if.ack_idx   = idx;
    cyc();
    u_if.frame_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    u_if.enable    = 1'b0;
    u_if.snk_valid = 1'b0;
    u_if.frame_ack = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({u_if.snk_ready, u_if.mem_write, u_if.mem_chipselect, u_if.irq, u_if.frame_done} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 00000", {u_if.snk_ready, u_if.mem_write,
               u_if.mem_chipselect, u_if.irq, u_if.frame_done});
    end
    total++;
    if (u_if.overflow_count !== '0) begin
      bad++; $display("FAIL reset_ovf: got %0d want 0", u_if.overflow_count);
    end
    total++;
    if (u_if.mem_clken !== 1'b1) begin
      bad++; $display("FAIL reset_clken: got %b want 1", u_if.mem_clken);
    end
  endtask

  task automatic test_basic();
    logic [15:0] l, r;
    logic [54:0] exp_v;
    do_reset();
    u_if.enable = 1'b1;
    cyc();
    for (int i = 0; i < 8; i++) begin
      l = 16'h1111 + 16'(i) * 16'h2222;
      r = l + 16'h1111;
      put(l, r);
      exp_v = {1'b1, 1'b1, 4'hF, 16'(BASE + i), l, r, (i % 4) == 3};
      total++;
      if (w_obs !== exp_v) begin
        bad++; $display("FAIL basic_write%0d: got %h want %h", i, w_obs, exp_v);
      end
      if ((i % 4) == 3) begin
        total++;
        if (u_if.frame_idx !== 1'(i / 4) || u_if.irq !== 1'b1) begin
          bad++; $display("FAIL basic_done%0d: got idx=%b irq=%b want idx=%0d irq=1",
                          i, u_if.frame_idx, u_if.irq, i / 4);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      put(16'hDEAD, 16'hBEEF);
      total++;
      if (u_if.mem_write !== 1'b0) begin
        bad++; $display("FAIL basic_drop%0d: got write=%b want 0", i, u_if.mem_write);
      end
    end
    total++;
    if (u_if.overflow_count !== 4'd3) begin
      bad++; $display("FAIL basic_ovf: got %0d want 3", u_if.overflow_count);
    end
    ack(1'b0);
    cyc(); cyc();
    put(16'h1234, 16'h5678);
    exp_v = {1'b1, 1'b1, 4'hF, 16'(BASE), 16'h1234, 16'h5678, 1'b0};
    total++;
    if (w_obs !== exp_v) begin
      bad++; $display("FAIL basic_resume: got %h want %h", w_obs, exp_v);
    end
    total++;
    if (u_if.overflow_count !== 4'd3 || u_if.irq !== 1'b1) begin
      bad++; $display("FAIL basic_resume_state: got ovf=%0d irq=%b want ovf=3 irq=1",
                      u_if.overflow_count, u_if.irq);
    end
    ack(1'b1);
    total++;
    if (u_if.irq !== 1'b0) begin
      bad++; $display("FAIL basic_irq_clear: got %b want 0", u_if.irq);
    end
    ack(1'b1);  // frame 1 is no longer full: ignored
    put(16'h0F0F, 16'hF0F0);
    exp_v = {1'b1, 1'b1, 4'hF, 16'(BASE + 1), 16'h0F0F, 16'hF0F0, 1'b0};
    total++;
    if (w_obs !== exp_v || u_if.irq !== 1'b0) begin
      bad++; $display("FAIL basic_stray_ack: got %h irq=%b want %h irq=0", w_obs, u_if.irq, exp_v);
    end
  endtask

  task automatic test_enable_drop();
    logic [54:0] exp_v;
    do_reset();
    u_if.enable = 1'b1;
    cyc();
    put(16'h0001, 16'h0002);
    put(16'h0003, 16'h0004);
    exp_v = {1'b1, 1'b1, 4'hF, 16'(BASE + 1), 16'h0003, 16'h0004, 1'b0};
    total++;
    if (w_obs !== exp_v) begin
      bad++; $display("FAIL en_second: got %h want %h", w_obs, exp_v);
    end
    u_if.enable = 1'b0;
    put(16'h5555, 16'h5555);  // offered as enable falls
    total++;
    if (u_if.mem_write !== 1'b0 || u_if.snk_ready !== 1'b0) begin
      bad++; $display("FAIL en_fall: got write=%b ready=%b want 0 0", u_if.mem_write, u_if.snk_ready);
    end
    u_if.enable = 1'b1;
    cyc();
    put(16'hAAAA, 16'hBBBB);
    exp_v = {1'b1, 1'b1, 4'hF, 16'(BASE), 16'hAAAA, 16'hBBBB, 1'b0};
    total++;
    if (w_obs !== exp_v) begin
      bad++; $display("FAIL en_restart: got %h want %h", w_obs, exp_v);
    end
  endtask

  task automatic test_ack_collide();
    logic [54:0] exp_v;
    do_reset();
    u_if.enable = 1'b1;
    cyc();
    for (int i = 0; i < 7; i++) put(16'(i), 16'(i + 100));
    u_if.frame_ack = 1'b1;
    u_if.ack_idx   = 1'b1;
    put(16'h7777, 16'h7777);
    u_if.frame_ack = 1'b0;
    total++;
    if (u_if.frame_done !== 1'b1 || u_if.frame_idx !== 1'b1 || u_if.irq !== 1'b1) begin
      bad++; $display("FAIL collide_done: got done=%b idx=%b irq=%b want 1 1 1",
                      u_if.frame_done, u_if.frame_idx, u_if.irq);
    end
    ack(1'b0);
    total++;
    if (u_if.irq !== 1'b1) begin
      bad++; $display("FAIL collide_full1_kept: got irq=%b want 1", u_if.irq);
    end
    cyc(); cyc();
    put(16'h0A0A, 16'h0B0B);
    exp_v = {1'b1, 1'b1, 4'hF, 16'(BASE), 16'h0A0A, 16'h0B0B, 1'b0};
    total++;
    if (w_obs !== exp_v) begin
      bad++; $display("FAIL collide_resume: got %h want %h", w_obs, exp_v);
    end
    ack(1'b1);
    total++;
    if (u_if.irq !== 1'b0) begin
      bad++; $display("FAIL collide_irq_clear: got %b want 0", u_if.irq);
    end
  endtask

  task automatic test_saturate_midreset();
    do_reset();
    u_if.enable = 1'b1;
    cyc();
    for (int i = 0; i < 8; i++) put(16'(i), 16'(i));
    for (int i = 0; i < 20; i++) put(16'hFFFF, 16'hFFFF);
    total++;
    if (u_if.overflow_count !== 4'(CMAX)) begin
      bad++; $display("FAIL sat_ovf: got %0d want %0d", u_if.overflow_count, CMAX);
    end
    ack(1'b0);
    cyc(); cyc();
    put(16'h1, 16'h2);
    put(16'h3, 16'h4);
    u_if.snk_valid = 1'b1;
    reset = 1'b1;
    cyc();
    u_if.snk_valid = 1'b0;
    reset = 1'b0;
    total++;
    if ({u_if.mem_write, u_if.frame_done, u_if.irq} !== 3'b000 || u_if.overflow_count !== '0) begin
      bad++; $display("FAIL midreset: got write=%b done=%b irq=%b ovf=%0d want 0 0 0 0",
                      u_if.mem_write, u_if.frame_done, u_if.irq, u_if.overflow_count);
    end
  endtask

  // Transaction-level model: two frame slots, a fill cursor and a drop counter.
  task automatic test_random();
    bit          m_full[2];
    int unsigned m_cur, m_off, m_ovf, m_last;
    bit          m_wait;
    logic [15:0] l, r;
    logic [54:0] exp_v;
    bit          exp_done;
    int unsigned sel, k;
    do_reset();
    m_full = '{0, 0};
    m_cur = 0; m_off = 0; m_ovf = 0; m_last = 0; m_wait = 0;
    u_if.enable = 1'b1;
    cyc();
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 65) begin
        l = 16'($urandom);
        r = 16'($urandom);
        put(l, r);
        if (!m_wait) begin
          exp_done = (m_off == FW - 1);
          exp_v = {1'b1, 1'b1, 4'hF, 16'(BASE + m_cur * FW + m_off), l, r, exp_done};
          if (exp_done) begin
            m_full[m_cur] = 1;
            m_last = m_cur;
            m_cur  = 1 - m_cur;
            m_off  = 0;
            m_wait = m_full[m_cur];
          end else begin
            m_off++;
          end
          total++;
          if (w_obs !== exp_v) begin
            bad++; $display("FAIL rand_write n=%0d: got %h want %h", n, w_obs, exp_v);
          end
        end else begin
          if (m_ovf < CMAX) m_ovf++;
          total++;
          if ({u_if.mem_write, u_if.mem_chipselect, u_if.frame_done} !== 3'b000) begin
            bad++; $display("FAIL rand_drop n=%0d: got %b want 000", n,
                            {u_if.mem_write, u_if.mem_chipselect, u_if.frame_done});
          end
        end
        total++;
        if (u_if.overflow_count !== 4'(m_ovf) || u_if.frame_idx !== 1'(m_last) ||
            u_if.irq !== (m_full[0] | m_full[1])) begin
          bad++; $display("FAIL rand_status n=%0d: got ovf=%0d idx=%b irq=%b want %0d %0d %b",
                          n, u_if.overflow_count, u_if.frame_idx, u_if.irq,
                          m_ovf, m_last, m_full[0] | m_full[1]);
        end
      end else if (sel < 80) begin
        cyc();
        total++;
        if (u_if.mem_write !== 1'b0) begin
          bad++; $display("FAIL rand_idle n=%0d: got write=%b want 0", n, u_if.mem_write);
        end
      end else begin
        k = $urandom_range(0, 1);
        ack(1'(k));
        m_full[k] = 0;
        if (m_wait && !m_full[m_cur]) m_wait = 0;
        cyc(); cyc();
        total++;
        if (u_if.irq !== (m_full[0] | m_full[1])) begin
          bad++; $display("FAIL rand_ack n=%0d: got irq=%b want %b", n, u_if.irq,
                          m_full[0] | m_full[1]);
        end
      end
    end
  endtask

  initial begin
    u_if.enable    = 1'b0;
    u_if.snk_valid = 1'b0;
    u_if.snk_left  = 16'h0;
    u_if.snk_right = 16'h0;
    u_if.frame_ack = 1'b0;
    u_if.ack_idx   = 1'b0;
    test_reset();
    test_basic();
    test_enable_drop();
    test_ack_collide();
    test_saturate_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
